// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the PWM ramp controller slice.
// Holds the ramp FSM state encoding, the duty width and the widened
// arithmetic type used for clamping and stepping without overflow.
package pwm_pkg;

    localparam int DUTY_W = 16;
    localparam int CALC_W = DUTY_W + 1;

    typedef logic [CALC_W-1:0] calc_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RAMP_UP   = 2'b01,
        HOLD      = 2'b10,
        RAMP_DOWN = 2'b11
    } ramp_state_t;

    function automatic calc_t umin(input calc_t a, input calc_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic calc_t umax(input calc_t a, input calc_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwm_tic_div.sv
// pwm_tic_div: PWM tick divider plus period counter.
// While run is high, tic fires once every TIC_DIV cycles and boundary fires
// on the tick that closes each MODULO-tick period. Both counters sit at zero
// whenever run is low or clear is pulsed, so a fresh start is phase-aligned.
module pwm_tic_div
    import pwm_pkg::*;
#(
    parameter int TIC_DIV = 100,
    parameter int MODULO  = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tic,
    output logic boundary
);

    localparam int DIV_W = (TIC_DIV > 1) ? $clog2(TIC_DIV) : 1;
    localparam int PER_W = (MODULO > 1) ? $clog2(MODULO) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIC_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(MODULO - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [PER_W-1:0] per_cnt;

    assign tic      = run && (div_cnt == DIV_LAST);
    assign boundary = tic && (per_cnt == PER_LAST);

    // Advance the divider every cycle and the period counter on each tick
    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            div_cnt <= '0;
            per_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start / soft-stop sequencer in front of pwm_gen.
// Generates the PWM tick and period-restart pulse and walks the duty
// command toward the clamped host target by RAMP_STEP once per period.
// Duty only ever changes together with o_START, so pwm_gen never sees a
// mid-period update.
// Optional macro PWM_RAMP_SOFTSTOP_EN: when defined, dropping i_ENABLE ramps
// the duty down to zero one step per period; when undefined, dropping
// i_ENABLE stops immediately exactly like i_ABORT.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int MODULO    = 10000,
    parameter int TIC_DIV   = 100,
    parameter int RAMP_STEP = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_ENABLE,
    input  logic              i_ABORT,
    input  logic [DUTY_W-1:0] i_TARGET,
    input  logic              i_TARGET_WR,
    input  logic [DUTY_W-1:0] i_MIN_DUTY,
    input  logic [DUTY_W-1:0] i_MAX_DUTY,
    output logic              o_PWM_TIC,
    output logic              o_START,
    output logic [DUTY_W-1:0] o_DUTY,
    output logic              o_BUSY,
    output logic              o_AT_TARGET,
    output logic [1:0]        o_STATE
);

    localparam calc_t MOD_C  = calc_t'(MODULO);
    localparam calc_t STEP_C = calc_t'(RAMP_STEP);

    ramp_state_t       state;
    ramp_state_t       step_state;
    ramp_state_t       hold_state;
    logic [DUTY_W-1:0] target_q;
    logic [DUTY_W-1:0] duty_q;
    logic              start_q;

    calc_t ceiling;
    calc_t eff_target;
    calc_t step_target;
    calc_t init_duty;
    calc_t duty_c;
    calc_t up_val;
    calc_t down_raw;
    calc_t down_val;
    calc_t step_duty;

    logic tic;
    logic boundary;
    logic run;
    logic clear;
    logic stop_now;
    logic start_run;
    logic soft_stop;

`ifdef PWM_RAMP_SOFTSTOP_EN
    assign soft_stop = !i_ENABLE;
    assign stop_now  = i_ABORT;
`else
    assign soft_stop = 1'b0;
    assign stop_now  = i_ABORT || (!i_ENABLE && (state != IDLE));
`endif

    assign run       = (state != IDLE);
    assign start_run = (state == IDLE) && i_ENABLE && (eff_target != '0) && !stop_now;
    assign clear     = stop_now || start_run;

    // Latch the host target; a simultaneous abort does not block the write
    always_ff @(posedge CLK) begin
        if (RST) begin
            target_q <= '0;
        end else if (i_TARGET_WR) begin
            target_q <= i_TARGET;
        end
    end

    // Clamp the latched target into [MIN, min(MAX, MODULO)], MAX winning a conflict
    always_comb begin
        ceiling     = umin(calc_t'(i_MAX_DUTY), MOD_C);
        eff_target  = '0;
        if (target_q != '0) begin
            eff_target = umin(umax(calc_t'(target_q), calc_t'(i_MIN_DUTY)), ceiling);
        end
        step_target = soft_stop ? '0 : eff_target;
        init_duty   = umin(calc_t'(i_MIN_DUTY), eff_target);
    end

    // One ramp step toward step_target, never passing it, plus the resulting state
    always_comb begin
        duty_c   = calc_t'(duty_q);
        up_val   = umin(duty_c + STEP_C, step_target);
        down_raw = (duty_c >= STEP_C) ? (duty_c - STEP_C) : '0;
        down_val = umax(down_raw, step_target);
        if (down_val < calc_t'(i_MIN_DUTY)) begin
            down_val = '0;
        end
        step_duty  = duty_c;
        step_state = HOLD;
        if (step_target > duty_c) begin
            step_duty  = up_val;
            step_state = (up_val == step_target) ? HOLD : RAMP_UP;
        end else if (step_target < duty_c) begin
            step_duty = down_val;
            if (down_val == '0) begin
                step_state = IDLE;
            end else if (down_val == step_target) begin
                step_state = HOLD;
            end else begin
                step_state = RAMP_DOWN;
            end
        end else if (duty_c == '0) begin
            step_state = IDLE;
        end
        hold_state = HOLD;
        if (eff_target > duty_c) begin
            hold_state = RAMP_UP;
        end else if (eff_target < duty_c) begin
            hold_state = RAMP_DOWN;
        end
    end

    // Ramp FSM: abort first, then IDLE exit, then per-period duty updates
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            duty_q  <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (stop_now) begin
                state   <= IDLE;
                duty_q  <= '0;
                start_q <= 1'b1;
            end else if (start_run) begin
                state   <= RAMP_UP;
                duty_q  <= DUTY_W'(init_duty);
                start_q <= 1'b1;
            end else if (boundary) begin
                start_q <= 1'b1;
                if ((state == HOLD) && !soft_stop) begin
                    state <= hold_state;
                end else begin
                    state  <= step_state;
                    duty_q <= DUTY_W'(step_duty);
                end
            end
        end
    end

    pwm_tic_div #(
        .TIC_DIV (TIC_DIV),
        .MODULO  (MODULO)
    ) u_tic_div (
        .clk      (CLK),
        .rst      (RST),
        .run      (run),
        .clear    (clear),
        .tic      (tic),
        .boundary (boundary)
    );

    assign o_PWM_TIC   = tic;
    assign o_START     = start_q;
    assign o_DUTY      = duty_q;
    assign o_BUSY      = (state != IDLE);
    assign o_STATE     = state;
    assign o_AT_TARGET = (state == HOLD) && (calc_t'(duty_q) == eff_target);

endmodule
